usb_pkt_tx: RTL and testbench

USB_PKT_TX -- requirements
Module: usb_pkt_tx

---
 rtl/usb_pkt_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_usb_pkt_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_pkt_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : usb_pkt_tx
// Purpose  : Serial USB packet transmitter (SYNC/PID/token/data/CRC/EOP) with
//            bit stuffing and NRZI line encoding, one bit-time per clock.
// Revision : 1.0 - initial release
// ============================================================================
module usb_pkt_tx #(
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             kind,
    input  logic [3:0]             pid,
    input  logic [6:0]             addr,
    input  logic [3:0]             endp,
    input  logic [8*MAX_BYTES-1:0] data,
    input  logic [LEN_W-1:0]       len,
    output logic                   busy,
    output logic                   done,
    output logic                   dp,
    output logic                   dm
);
    localparam int CNT_W = $clog2(8 * MAX_BYTES + 1);

    localparam logic [LEN_W-1:0] c_max_len    = LEN_W'(MAX_BYTES);
    localparam logic [4:0]       c_crc5_poly  = 5'h14;
    localparam logic [15:0]      c_crc16_poly = 16'hA001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_PID   = 3'd2,
        S_TOKEN = 3'd3,
        S_DATA  = 3'd4,
        S_CRC5  = 3'd5,
        S_CRC16 = 3'd6,
        S_EOP   = 3'd7
    } state_t;

    // r_state/r_cnt/r_stuff describe the bit that will be driven at the next edge
    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_nbits;
    logic [CNT_W-1:0]       w_last;
    logic                   r_stuff;
    logic [2:0]             r_ones;
    logic                   r_j;
    logic [1:0]             r_kind;
    logic [7:0]             r_pid;
    logic [10:0]            r_token;
    logic [8*MAX_BYTES-1:0] r_data;
    logic [4:0]             r_crc5;
    logic [4:0]             w_crc5_nx;
    logic [15:0]            r_crc16;
    logic [15:0]            w_crc16_nx;
    logic [LEN_W-1:0]       w_len;
    logic                   w_accept;
    logic                   w_raw;
    logic                   w_line;

    assign w_len    = (len > c_max_len) ? c_max_len : len;
    assign w_accept = (r_state == S_IDLE) && start && (kind != 2'b11);
    assign w_line   = w_raw ? r_j : ~r_j;

    assign w_crc5_nx  = {1'b0, r_crc5[4:1]} ^ ((r_crc5[0] ^ w_raw) ? c_crc5_poly : 5'h00);
    assign w_crc16_nx = {1'b0, r_crc16[15:1]} ^ ((r_crc16[0] ^ w_raw) ? c_crc16_poly : 16'h0000);

    always_comb begin
        w_raw = 1'b0;
        case (r_state)
            S_SYNC:  w_raw = (r_cnt == CNT_W'(7));
            S_PID:   w_raw = r_pid[0];
            S_TOKEN: w_raw = r_token[0];
            S_DATA:  w_raw = r_data[0];
            S_CRC5:  w_raw = ~r_crc5[0];
            S_CRC16: w_raw = ~r_crc16[0];
            default: w_raw = 1'b0;
        endcase
        if (r_stuff) begin
            w_raw = 1'b0;
        end
    end

    always_comb begin
        w_last       = '0;
        w_next_state = S_EOP;
        case (r_state)
            S_SYNC: begin
                w_last       = CNT_W'(7);
                w_next_state = S_PID;
            end
            S_PID: begin
                w_last = CNT_W'(7);
                case (r_kind)
                    2'b00:   w_next_state = S_TOKEN;
                    2'b01:   w_next_state = (r_nbits == '0) ? S_CRC16 : S_DATA;
                    default: w_next_state = S_EOP;
                endcase
            end
            S_TOKEN: begin
                w_last       = CNT_W'(10);
                w_next_state = S_CRC5;
            end
            S_DATA: begin
                w_last       = r_nbits - CNT_W'(1);
                w_next_state = S_CRC16;
            end
            S_CRC5:  w_last = CNT_W'(4);
            S_CRC16: w_last = CNT_W'(15);
            default: w_last = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_nbits <= '0;
            r_stuff <= 1'b0;
            r_ones  <= '0;
            r_j     <= 1'b1;
            r_kind  <= '0;
            r_pid   <= '0;
            r_token <= '0;
            r_crc5  <= 5'h1F;
            r_crc16 <= 16'hFFFF;
            busy    <= 1'b0;
            done    <= 1'b0;
            dp      <= 1'b1;
            dm      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    // First SYNC bit (raw 0 from J) goes out on this very edge
                    r_kind  <= kind;
                    r_pid   <= {~pid, pid};
                    r_token <= {endp, addr};
                    r_data  <= data;
                    r_nbits <= CNT_W'(w_len) << 3;
                    r_state <= S_SYNC;
                    r_cnt   <= CNT_W'(1);
                    r_stuff <= 1'b0;
                    r_ones  <= '0;
                    r_crc5  <= 5'h1F;
                    r_crc16 <= 16'hFFFF;
                    r_j     <= 1'b0;
                    dp      <= 1'b0;
                    dm      <= 1'b1;
                    busy    <= 1'b1;
                end
            end else if (r_state == S_EOP && !r_stuff) begin
                r_cnt <= r_cnt + CNT_W'(1);
                case (r_cnt[1:0])
                    2'd0, 2'd1: begin
                        dp <= 1'b0;
                        dm <= 1'b0;
                    end
                    2'd2: begin
                        dp   <= 1'b1;
                        dm   <= 1'b0;
                        done <= 1'b1;
                    end
                    default: begin
                        dp      <= 1'b1;
                        dm      <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end else begin
                r_j <= w_line;
                dp  <= w_line;
                dm  <= ~w_line;
                if (r_stuff) begin
                    r_stuff <= 1'b0;
                    r_ones  <= '0;
                end else begin
                    if (w_raw) begin
                        if (r_ones == 3'd5) begin
                            r_stuff <= 1'b1;
                            r_ones  <= '0;
                        end else begin
                            r_ones <= r_ones + 3'd1;
                        end
                    end else begin
                        r_ones <= '0;
                    end
                    case (r_state)
                        S_PID:   r_pid <= r_pid >> 1;
                        S_TOKEN: begin
                            r_token <= r_token >> 1;
                            r_crc5  <= w_crc5_nx;
                        end
                        S_DATA: begin
                            r_data  <= r_data >> 1;
                            r_crc16 <= w_crc16_nx;
                        end
                        S_CRC5:  r_crc5  <= r_crc5 >> 1;
                        S_CRC16: r_crc16 <= r_crc16 >> 1;
                        default: ;
                    endcase
                    if (r_cnt == w_last) begin
                        r_cnt   <= '0;
                        r_state <= w_next_state;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_usb_pkt_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_usb_pkt_tx
// Purpose  : Self-checking bench for usb_pkt_tx: directed table, random packets
//            against a packet-level reference model, and reset corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_pkt_tx;
    localparam int MAX_BYTES = 64;
    localparam int LEN_W     = $clog2(MAX_BYTES + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [1:0]             kind;
    logic [3:0]             pid;
    logic [6:0]             addr;
    logic [3:0]             endp;
    logic [8*MAX_BYTES-1:0] data;
    logic [LEN_W-1:0]       len;
    logic                   busy;
    logic                   done;
    logic                   dp;
    logic                   dm;

    usb_pkt_tx #(.MAX_BYTES(MAX_BYTES)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .kind (kind),
        .pid  (pid),
        .addr (addr),
        .endp (endp),
        .data (data),
        .len  (len),
        .busy (busy),
        .done (done),
        .dp   (dp),
        .dm   (dm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
        int         len;
        int         fill;        // 0 ascii "1..", 1 all 0xFF, 2 random
        int         exp_bits;    // destuffed bits before EOP
        int         exp_cycles;  // busy cycles, 0 = not fixed
        int         exp_pid;
        int         exp_crc;     // CRC16 field, -1 = not fixed
    } vec_t;

    int       checks   = 0;
    int       failures = 0;
    logic [7:0] pay [MAX_BYTES];
    bit       exp_dp[$], exp_dm[$], exp_busy[$], exp_done[$];
    logic     cap_dp[$], cap_dm[$], cap_busy[$];
    bit       dbits[$];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Packet-level reference: field list, CRCs, stuffing, NRZI, EOP, idle
    task automatic build_model(input logic [1:0] k, input logic [3:0] p,
                               input logic [6:0] a, input logic [3:0] e, input int n);
        bit raw[$];
        bit st[$];
        logic [7:0]  pb;
        logic [4:0]  c5;
        logic [15:0] c16;
        bit tok[$];
        int ones;
        bit line;
        raw = {};
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        pb = {~p, p};
        for (int i = 0; i < 8; i++) raw.push_back(pb[i]);
        if (k == 2'd0) begin
            tok = {};
            for (int i = 0; i < 7; i++) tok.push_back(a[i]);
            for (int i = 0; i < 4; i++) tok.push_back(e[i]);
            c5 = 5'h1F;
            foreach (tok[i]) begin
                raw.push_back(tok[i]);
                c5 = (c5[0] ^ tok[i]) ? ((c5 >> 1) ^ 5'h14) : (c5 >> 1);
            end
            c5 = c5 ^ 5'h1F;
            for (int i = 0; i < 5; i++) raw.push_back(c5[i]);
        end else if (k == 2'd1) begin
            c16 = 16'hFFFF;
            for (int b = 0; b < n; b++) begin
                for (int i = 0; i < 8; i++) raw.push_back(pay[b][i]);
                c16 = c16 ^ {8'h00, pay[b]};
                for (int i = 0; i < 8; i++)
                    c16 = c16[0] ? ((c16 >> 1) ^ 16'hA001) : (c16 >> 1);
            end
            c16 = c16 ^ 16'hFFFF;
            for (int i = 0; i < 16; i++) raw.push_back(c16[i]);
        end
        st   = {};
        ones = 0;
        foreach (raw[i]) begin
            st.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                st.push_back(1'b0);
                ones = 0;
            end
        end
        exp_dp = {}; exp_dm = {}; exp_busy = {}; exp_done = {};
        line = 1'b1;
        foreach (st[i]) begin
            if (!st[i]) line = ~line;
            exp_dp.push_back(line); exp_dm.push_back(~line);
            exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            exp_dp.push_back(1'b0); exp_dm.push_back(1'b0);
            exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
        end
        exp_dp.push_back(1'b1); exp_dm.push_back(1'b0); exp_busy.push_back(1'b1); exp_done.push_back(1'b1);
        exp_dp.push_back(1'b1); exp_dm.push_back(1'b0); exp_busy.push_back(1'b0); exp_done.push_back(1'b0);
    endtask

    function automatic longint field(int off, int w);
        longint v = 0;
        for (int i = 0; i < w; i++)
            if (off + i >= 0 && off + i < dbits.size() && dbits[off + i]) v |= (longint'(1) << i);
        return v;
    endfunction

    // Starts on a negedge with busy=0 and returns on the negedge where busy=0 again
    task automatic send(input logic [1:0] k, input logic [3:0] p, input logic [6:0] a,
                        input logic [3:0] e, input int ln, input int exp_bits,
                        input int exp_cycles, input int exp_pid, input int exp_crc);
        int  n;
        int  first_bad;
        int  busy_cnt;
        int  done_cnt;
        int  guard;
        int  ones;
        bit  prev;
        bit  r;
        bit  pay_ok;
        n = (ln > MAX_BYTES) ? MAX_BYTES : ln;
        build_model(k, p, a, e, n);
        kind = k; pid = p; addr = a; endp = e; len = LEN_W'(ln);
        for (int b = 0; b < MAX_BYTES; b++) data[8*b +: 8] = pay[b];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kind = 2'($urandom); pid = 4'($urandom); addr = 7'($urandom); endp = 4'($urandom);
        len = LEN_W'($urandom);
        for (int b = 0; b < MAX_BYTES; b++) data[8*b +: 8] = 8'($urandom);
        cap_dp = {}; cap_dm = {}; cap_busy = {};
        first_bad = -1; busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < exp_dp.size(); i++) begin
            if (i > 0) @(negedge clk);
            cap_dp.push_back(dp); cap_dm.push_back(dm); cap_busy.push_back(busy);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (first_bad < 0 && (dp !== exp_dp[i] || dm !== exp_dm[i] ||
                                  busy !== exp_busy[i] || done !== exp_done[i]))
                first_bad = i;
            if (i == 3) start = 1'b1;   // start while busy must be ignored
            if (i == 4) start = 1'b0;
        end
        guard = 0;
        while (busy !== 1'b0 && guard < 1000) begin
            @(negedge clk);
            busy_cnt++;
            guard++;
        end
        check("line_stream_first_bad_cycle", first_bad, -1);
        check("done_pulses", done_cnt, 1);
        if (exp_cycles > 0) check("busy_cycles", busy_cnt, exp_cycles);
        // NRZI decode and destuff the captured line up to EOP
        dbits = {}; prev = 1'b1; ones = 0;
        for (int i = 0; i < cap_dp.size(); i++) begin
            if (cap_busy[i] !== 1'b1 || (cap_dp[i] === 1'b0 && cap_dm[i] === 1'b0)) break;
            r    = (cap_dp[i] === prev);
            prev = (cap_dp[i] === 1'b1);
            if (ones == 6) begin
                ones = 0;
            end else begin
                dbits.push_back(r);
                ones = r ? ones + 1 : 0;
            end
        end
        check("decoded_bits", dbits.size(), exp_bits);
        check("pid_byte", field(8, 8), exp_pid);
        if (k == 2'd1) begin
            pay_ok = 1'b1;
            for (int b = 0; b < n; b++)
                if (field(16 + 8*b, 8) != longint'(pay[b])) pay_ok = 1'b0;
            check("payload", pay_ok, 1);
        end
        if (exp_crc >= 0) check("crc16_field", field(dbits.size() - 16, 16), exp_crc);
    endtask

    vec_t vecs[6];

    initial begin
        logic [1:0] k;
        logic [3:0] p;
        int         n;
        int         eb;
        int         dsum;
        vecs[0] = '{2'd2, 4'h2, 7'h00, 4'h0,   0, 0,  16,  19, 'hD2, -1};
        vecs[1] = '{2'd0, 4'h1, 7'h15, 4'hE,   0, 0,  32,   0, 'hE1, -1};
        vecs[2] = '{2'd1, 4'h3, 7'h00, 4'h0,   9, 0, 104, 107, 'hC3, 'hB4C8};
        vecs[3] = '{2'd1, 4'h3, 7'h00, 4'h0,   0, 0,  32,  35, 'hC3, 0};
        vecs[4] = '{2'd1, 4'hB, 7'h00, 4'h0,   2, 1,  48,  56, 'h4B, 'hFFFF};
        vecs[5] = '{2'd1, 4'h3, 7'h00, 4'h0, 127, 2, 544,   0, 'hC3, -1};

        rst = 1'b1; start = 1'b0; kind = '0; pid = '0; addr = '0; endp = '0;
        data = '0; len = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_line", {dp, dm}, 2'b10);
        rst = 1'b0;
        @(negedge clk);

        // Reserved kind is never accepted
        kind = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("reserved_kind_busy", busy, 0);
        @(negedge clk);
        check("reserved_kind_line", {dp, dm}, 2'b10);

        // Directed table, issued back to back
        foreach (vecs[v]) begin
            for (int b = 0; b < MAX_BYTES; b++)
                pay[b] = (vecs[v].fill == 0) ? 8'(8'h31 + b) :
                         (vecs[v].fill == 1) ? 8'hFF : 8'($urandom);
            send(vecs[v].kind, vecs[v].pid, vecs[v].addr, vecs[v].endp, vecs[v].len,
                 vecs[v].exp_bits, vecs[v].exp_cycles, vecs[v].exp_pid, vecs[v].exp_crc);
        end

        // Random packets, payload biased toward 0xFF to exercise stuffing
        for (int r = 0; r < 16; r++) begin
            k = 2'($urandom_range(0, 2));
            p = 4'($urandom);
            n = $urandom_range(0, 70);
            for (int b = 0; b < MAX_BYTES; b++)
                pay[b] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            eb = (k == 2'd0) ? 32 : (k == 2'd2) ? 16 : 32 + 8 * ((n > MAX_BYTES) ? MAX_BYTES : n);
            send(k, p, 7'($urandom), 4'($urandom), n, eb, 0, int'({~p, p}), -1);
        end

        // Reset in the middle of the payload aborts without EOP or done
        for (int b = 0; b < MAX_BYTES; b++) pay[b] = 8'($urandom);
        kind = 2'd1; pid = 4'h3; len = LEN_W'(8);
        for (int b = 0; b < MAX_BYTES; b++) data[8*b +: 8] = pay[b];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        check("mid_data_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_line_j", {dp, dm}, 2'b10);
        check("abort_busy", busy, 0);
        dsum = 0;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) dsum++;
            @(negedge clk);
        end
        check("abort_quiet_cycles", dsum, 0);

        // start together with rst is ignored
        kind = 2'd2; pid = 4'h2; rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("start_with_rst_busy", busy, 0);
        @(negedge clk);
        check("start_with_rst_line", {dp, dm}, 2'b10);

        // Recovery after the reset tests
        send(2'd2, 4'hA, 7'h00, 4'h0, 0, 16, 19, 'h5A, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
